// File: rtl/pulse_gen_pkg.sv
// Shared types for the pulse train generator: FSM state encoding and default counter width.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping; load has priority over enable.
module load_down_counter
    import pulse_gen_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (en && (value_q != '0)) begin
            value_d = value_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Programmable pulse train source: COUNT pulses of WIDTH cycles high separated by GAP cycles low.
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [CNT_W-1:0] count,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_left
);

    // Phase lengths are stored as (length-1) so the timer reaches zero on the last phase cycle.
    function automatic logic [CNT_W-1:0] len_minus_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wm1_q, wm1_d;
    logic [CNT_W-1:0] gm1_q, gm1_d;
    logic             out_q, busy_q, done_q;
    logic             done_d;

    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_value_unused;

    logic             pc_load, pc_en, pc_zero_unused;
    logic [CNT_W-1:0] pc_val;
    logic [CNT_W-1:0] pc_value;

    load_down_counter #(.W(CNT_W)) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .value    (tmr_value_unused),
        .zero     (tmr_zero)
    );

    load_down_counter #(.W(CNT_W)) u_pulse_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_val),
        .en       (pc_en),
        .value    (pc_value),
        .zero     (pc_zero_unused)
    );

    always_comb begin
        state_d  = state_q;
        wm1_d    = wm1_q;
        gm1_d    = gm1_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        pc_load  = 1'b0;
        pc_val   = '0;
        pc_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort in the same cycle drops the start request
                if (start && !abort) begin
                    if (count != '0) begin
                        state_d  = HIGH;
                        wm1_d    = len_minus_one(width);
                        gm1_d    = len_minus_one(gap);
                        tmr_load = 1'b1;
                        tmr_val  = len_minus_one(width);
                        pc_load  = 1'b1;
                        pc_val   = count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = IDLE;
                    pc_load = 1'b1;
                end else if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else if (pc_value > CNT_W'(1)) begin
                    state_d  = LOW;
                    tmr_load = 1'b1;
                    tmr_val  = gm1_q;
                    pc_en    = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    pc_load = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_d = IDLE;
                    pc_load = 1'b1;
                end else if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = wm1_q;
                end
            end
            default: begin
                state_d = IDLE;
                pc_load = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state so they change only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        wm1_q <= wm1_d;
        gm1_q <= gm1_d;
    end

    assign out         = out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_left = pc_value;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Randomized and directed bench for pulse_train_generator against a queue-based train model.
module tb_pulse_train_generator;

    localparam int CNT_W = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] width = '0;
    logic [CNT_W-1:0] gap   = '0;
    logic [CNT_W-1:0] count = '0;
    logic             out, busy, done;
    logic [CNT_W-1:0] pulses_left;

    int n_chk = 0;
    int n_err = 0;
    int edges = 0;
    logic prev_out = 1'b0;

    pulse_train_generator #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .width       (width),
        .gap         (gap),
        .count       (count),
        .out         (out),
        .busy        (busy),
        .done        (done),
        .pulses_left (pulses_left)
    );

    always #5 clk = ~clk;

    // Model: a train is expanded into a list of per-cycle output tuples when accepted.
    typedef struct packed {
        logic             o;
        logic             b;
        logic             d;
        logic [CNT_W-1:0] pl;
    } ent_t;

    ent_t q[$];
    ent_t cur = '0;

    task automatic build(input int w, input int g, input int c);
        if (w == 0) w = 1;
        if (g == 0) g = 1;
        for (int p = 0; p < c; p++) begin
            for (int i = 0; i < w; i++) q.push_back({1'b1, 1'b1, 1'b0, CNT_W'(c - p)});
            if (p < c - 1)
                for (int i = 0; i < g; i++) q.push_back({1'b0, 1'b1, 1'b0, CNT_W'(c - p - 1)});
        end
        q.push_back({1'b0, 1'b0, 1'b1, CNT_W'(0)});
    endtask

    always @(posedge clk or negedge rst_n) begin : ref_model
        if (!rst_n) begin
            q.delete();
            cur = '0;
        end else if (cur.b && abort) begin
            q.delete();
            cur = '0;
        end else begin
            if (!cur.b && start && !abort) build(int'(width), int'(gap), int'(count));
            if (q.size() > 0) cur = q.pop_front();
            else cur = '0;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk_eq("out", 32'(out), 32'(cur.o));
        chk_eq("busy", 32'(busy), 32'(cur.b));
        chk_eq("done", 32'(done), 32'(cur.d));
        chk_eq("pulses_left", 32'(pulses_left), 32'(cur.pl));
        if (out && !prev_out) edges++;
        prev_out = out;
    endtask

    task automatic fire(input int w, input int g, input int c);
        width = CNT_W'(w);
        gap   = CNT_W'(g);
        count = CNT_W'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Starts a train and measures busy time against C*W + (C-1)*G.
    task automatic run_train(input int w, input int g, input int c);
        int n, we, ge, exp_n;
        n = 0;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        exp_n = (c == 0) ? 0 : c * we + (c - 1) * ge;
        fire(w, g, c);
        for (int k = 0; k < 4000 && !done; k++) begin
            if (busy) n++;
            tick();
        end
        chk_eq("train_done_seen", 32'(done), 32'd1);
        chk_eq("train_busy_len", 32'(n), 32'(exp_n));
        tick();
    endtask

    initial begin
        logic [5:0] pat;
        tick();
        chk_eq("rst_out", 32'(out), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_pl", 32'(pulses_left), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: 1/1/3 gives isolated single-cycle pulses
        edges = 0;
        pat = 6'b010101;
        fire(1, 1, 3);
        for (int i = 0; i < 6; i++) begin
            chk_eq("t1_out", 32'(out), 32'(pat[i]));
            chk_eq("t1_done", 32'(done), (i == 5) ? 32'd1 : 32'd0);
            tick();
        end
        chk_eq("t1_edges", 32'(edges), 32'd3);

        // T2 and max-value trains
        run_train(4, 2, 2);
        run_train(255, 255, 2);
        run_train(0, 0, 255);
        run_train(3, 255, 1);

        // T3: empty train
        fire(5, 5, 0);
        chk_eq("t3_done", 32'(done), 32'd1);
        chk_eq("t3_busy", 32'(busy), 32'd0);
        chk_eq("t3_out", 32'(out), 32'd0);
        tick();
        chk_eq("t3_done_clr", 32'(done), 32'd0);

        // T4: zero width/gap promoted to one
        fire(0, 0, 2);
        chk_eq("t4_c1", 32'(out), 32'd1);
        tick();
        chk_eq("t4_c2", 32'(out), 32'd0);
        tick();
        chk_eq("t4_c3", 32'(out), 32'd1);
        tick();
        chk_eq("t4_done", 32'(done), 32'd1);
        tick();

        // T5: start while busy ignored; back-to-back on the done cycle
        fire(2, 1, 2);
        tick();
        width = 8'd9; gap = 8'd9; count = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && !done; k++) tick();
        chk_eq("t5_done_seen", 32'(done), 32'd1);
        fire(1, 1, 1);
        chk_eq("t5_b2b_high", 32'(out), 32'd1);
        tick();
        tick();

        // IDLE abort+start: abort wins
        width = 8'd2; count = 8'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_eq("idle_abort_busy", 32'(busy), 32'd0);
        tick();

        // T6: abort in second HIGH, then reset mid-LOW
        fire(3, 2, 4);
        for (int i = 0; i < 5; i++) tick();
        chk_eq("t6_in_high2", 32'(out), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_eq("t6_abort_out", 32'(out), 32'd0);
        chk_eq("t6_abort_busy", 32'(busy), 32'd0);
        chk_eq("t6_abort_done", 32'(done), 32'd0);
        tick();
        tick();
        fire(3, 4, 3);
        for (int i = 0; i < 3; i++) tick();
        chk_eq("t6_in_low", 32'(busy & ~out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_out", 32'(out), 32'd0);
        chk_eq("t6_rst_busy", 32'(busy), 32'd0);
        chk_eq("t6_rst_done", 32'(done), 32'd0);
        chk_eq("t6_rst_pl", 32'(pulses_left), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            width = CNT_W'($urandom_range(0, 5));
            gap   = CNT_W'($urandom_range(0, 5));
            count = CNT_W'($urandom_range(0, 5));
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
